// File: rtl/axilite_slave_regfile.sv
// AXI4-Lite slave register file.
// Register 0 is a read-only ID; registers 1..NUM_REGS-1 are read/write and
// are exported on reg_o with a one-cycle wr_pulse_o strobe per committed write.
// Write and read channels run independently, one transaction outstanding each.
// Optional feature macro: AXIL_SLV_ERR_RESP_EN
//   defined   : out-of-window accesses and writes to register 0 answer SLVERR,
//               out-of-window reads return 32'hDEADBEEF.
//   undefined : every response is OKAY, out-of-window reads return 0.
module axilite_slave_regfile #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h44A00000,
    parameter int                NUM_REGS  = 16,
    parameter logic [31:0]       ID_VALUE  = 32'h01234567
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [ADDR_W-1:0]        s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [NUM_REGS*32-1:0]   reg_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int                IDX_W       = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] WIN_BYTES   = ADDR_W'(NUM_REGS * 4);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
`ifdef AXIL_SLV_ERR_RESP_EN
    localparam logic [1:0]        MISS_RESP   = RESP_SLVERR;
    localparam logic [31:0]       MISS_DATA   = 32'hDEADBEEF;
`else
    localparam logic [1:0]        MISS_RESP   = RESP_OKAY;
    localparam logic [31:0]       MISS_DATA   = 32'h0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}                    r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [NUM_REGS-1:0][31:0] regs;
    logic                      active;
    logic [ADDR_W-1:0]         aw_addr_q;
    logic [31:0]               w_data_q;
    logic [3:0]                w_strb_q;

    logic aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] wr_addr, wr_off, rd_off;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_hit, rd_hit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [1:0]        wr_resp;

    // Readies are held low for the first cycle after reset so every output
    // matches the reset state on the edge that sampled rst.
    assign s_axi_awready = active && (w_state == W_IDLE || w_state == W_GOT_W);
    assign s_axi_wready  = active && (w_state == W_IDLE || w_state == W_GOT_AW);
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_arready = active && (r_state == R_IDLE);
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign reg_o         = regs;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid  && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = (w_next == W_RESP) && (w_state != W_RESP);

    // The half of a split write that arrived first comes from its capture register.
    assign wr_addr = (w_state == W_GOT_AW) ? aw_addr_q : s_axi_awaddr;
    assign wr_data = (w_state == W_GOT_W)  ? w_data_q  : s_axi_wdata;
    assign wr_strb = (w_state == W_GOT_W)  ? w_strb_q  : s_axi_wstrb;

    assign wr_off = wr_addr - BASE_ADDR;
    assign wr_hit = (wr_addr >= BASE_ADDR) && (wr_off < WIN_BYTES);
    assign wr_idx = wr_off[IDX_W+1:2];
    assign rd_off = s_axi_araddr - BASE_ADDR;
    assign rd_hit = (s_axi_araddr >= BASE_ADDR) && (rd_off < WIN_BYTES);
    assign rd_idx = rd_off[IDX_W+1:2];

`ifdef AXIL_SLV_ERR_RESP_EN
    assign wr_resp = (wr_hit && wr_idx != '0) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
`endif

    // Write channel next-state: accept AW and W in either order, then respond.
    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of latches.
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_RESP;
                else if (aw_hs)    w_next = W_GOT_AW;
                else if (w_hs)     w_next = W_GOT_W;
            end
            W_GOT_AW: if (w_hs)         w_next = W_RESP;
            W_GOT_W:  if (aw_hs)        w_next = W_RESP;
            W_RESP:   if (s_axi_bready) w_next = W_IDLE;
            default:                    w_next = W_IDLE;
        endcase
    end

    // Read channel next-state: one beat per AR, held until rready.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)        r_next = R_DATA;
            R_DATA:  if (s_axi_rready) r_next = R_IDLE;
            default:                   r_next = R_IDLE;
        endcase
    end

    // State registers and the post-reset ready enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop sees pre-edge values; this is
        // also why a read and a write to the same register on one edge returns old data.
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            active  <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            active  <= 1'b1;
        end
    end

    // Capture the first half of a split write.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath capture, only read after its own handshake, so no reset.
        if (aw_hs) aw_addr_q <= s_axi_awaddr;
        if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
        end
    end

    // Register array, write response and per-register write strobes.
    always_ff @(posedge clk) begin
        // NOTE: the register array is visible on reg_o, so unlike a RAM it is reset.
        if (rst) begin
            regs        <= '0;
            regs[0]     <= ID_VALUE;
            s_axi_bresp <= RESP_OKAY;
            wr_pulse_o  <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (commit) begin
                s_axi_bresp <= wr_resp;
                if (wr_hit && wr_idx != '0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                    wr_pulse_o[wr_idx] <= 1'b1;
                end
            end
        end
    end

    // Read data and response, captured on the AR handshake and held until rready.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            if (rd_hit) begin
                s_axi_rdata <= regs[rd_idx];
                s_axi_rresp <= RESP_OKAY;
            end else begin
                s_axi_rdata <= MISS_DATA;
                s_axi_rresp <= MISS_RESP;
            end
        end
    end

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// Self-checking bench for axilite_slave_regfile (default parameters).
// Expected B/R responses are queued when a request is driven and compared
// when the DUT answers; a small register model tracks expected contents.
module tb_axilite_slave_regfile;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h44A00000;
    localparam logic [31:0] ID       = 32'h01234567;
`ifdef AXIL_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NUM_REGS*32-1:0] reg_o;
    logic [NUM_REGS-1:0]    wr_pulse_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NUM_REGS];
    int pulse_cnt [NUM_REGS];
    int exp_pulse [NUM_REGS];
    int b_hs_cnt = 0;
    logic [1:0] b_q [$];
    rd_exp_t    r_q [$];

    axilite_slave_regfile dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) if (wr_pulse_o[i]) pulse_cnt[i]++;
        if (bvalid && bready) b_hs_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    function automatic bit tb_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + NUM_REGS * 4);
    endfunction

    function automatic int tb_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [31:0] a);
        if (ERR_EN && (!tb_hit(a) || tb_idx(a) == 0)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic rd_exp_t exp_read(input logic [31:0] a);
        rd_exp_t e;
        if (tb_hit(a)) begin
            e.data = model[tb_idx(a)];
            e.resp = 2'b00;
        end else begin
            e.data = ERR_EN ? 32'hDEADBEEF : 32'h0;
            e.resp = ERR_EN ? 2'b10 : 2'b00;
        end
        return e;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (tb_hit(a) && tb_idx(a) != 0) begin
            idx = tb_idx(a);
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            exp_pulse[idx]++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for bvalid, then complete B and compare the queued response.
    task automatic wait_b(input string name);
        int n;
        logic [1:0] got, exp;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        checks++;
        if (!bvalid) begin
            errors++;
            $display("FAIL %s_b_timeout: bvalid=%b required 1", name, bvalid);
            b_q.delete();
            return;
        end
        bready = 1'b1;
        got = bresp;
        exp = b_q.pop_front();
        tick();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_bresp: got %b required %b", name, got, exp);
        end
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_bvalid_drop: got %b required 0", name, bvalid);
        end
    endtask

    // AW and W presented together; checks 1-cycle response latency.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string name);
        int n;
        bit aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            checks++; errors++;
            $display("FAIL %s_aw_w_timeout: awvalid=%b wvalid=%b required handshake", name, awvalid, wvalid);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        b_q.push_back(exp_bresp(a));
        model_write(a, d, s);
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_b_latency: bvalid=%b required 1", name, bvalid);
        end
        wait_b(name);
    endtask

    // Single read; checks 1-cycle latency and compares against the queued expectation.
    task automatic do_read(input logic [31:0] a, input string name);
        int n;
        bit hs;
        rd_exp_t e;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        r_q.push_back(exp_read(a));
        n = 0;
        hs = 1'b0;
        while (!hs && n < 20) begin
            hs = arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        if (!hs) begin
            checks++; errors++;
            $display("FAIL %s_ar_timeout: arready=%b required 1", name, arready);
            r_q.delete();
            return;
        end
        e = r_q.pop_front();
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_r_latency: rvalid=%b required 1", name, rvalid);
        end
        checks++;
        if (rdata !== e.data || rresp !== e.resp) begin
            errors++;
            $display("FAIL %s_rdata: got %h/%b required %h/%b", name, rdata, rresp, e.data, e.resp);
        end
        tick();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_rvalid_drop: got %b required 0", name, rvalid);
        end
    endtask

    // Split write: first channel, `gap` cycles, then the other channel.
    task automatic write_sep(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit w_first, input int gap, input string name);
        awaddr = a; wdata = d; wstrb = s;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_ready: aw/w ready %b%b required 11", name, awready, wready);
        end
        if (w_first) wvalid = 1'b1; else awvalid = 1'b1;
        tick();
        wvalid = 1'b0; awvalid = 1'b0;
        checks++;
        if ({awready, wready, bvalid} !== (w_first ? 3'b100 : 3'b010)) begin
            errors++;
            $display("FAIL %s_half_state: awready,wready,bvalid=%b required %b", name,
                     {awready, wready, bvalid}, (w_first ? 3'b100 : 3'b010));
        end
        repeat (gap - 1) tick();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_early_b: bvalid=%b required 0", name, bvalid);
        end
        if (w_first) awvalid = 1'b1; else wvalid = 1'b1;
        tick();
        wvalid = 1'b0; awvalid = 1'b0;
        b_q.push_back(exp_bresp(a));
        model_write(a, d, s);
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_b_latency: bvalid=%b required 1", name, bvalid);
        end
        wait_b(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            model[i] = (i == 0) ? ID : 32'h0;
            pulse_cnt[i] = 0;
            exp_pulse[i] = 0;
        end
        repeat (3) tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b0 ||
            rresp !== 2'b0 || rdata !== 32'h0 || wr_pulse_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b%b%b valid=%b%b resp=%b/%b rdata=%h pulse=%h required all 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_pulse_o);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++;
            if (reg_o[32*i +: 32] !== model[i]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h required %h", i, reg_o[32*i +: 32], model[i]);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 111", {awready, wready, arready});
        end
        do_read(BASE, "read_id");
    endtask

    task automatic test_write_read();
        int start;
        start = pulse_cnt[1];
        do_write(BASE + 4, 32'h4b, 4'hF, "wr_4b");
        do_write(BASE + 4, 32'h36, 4'hF, "wr_36");
        do_write(BASE + 4, 32'h98, 4'hF, "wr_98");
        do_read(BASE + 4, "rd_98");
        checks++;
        if (pulse_cnt[1] - start !== 3) begin
            errors++;
            $display("FAIL wr_pulse1_count: got %0d required 3", pulse_cnt[1] - start);
        end
    endtask

    task automatic test_split();
        int start;
        start = b_hs_cnt;
        write_sep(BASE + 8,  32'hAABBCCDD, 4'b0101, 1'b1, 4, "w_first");
        write_sep(BASE + 12, 32'hAABBCCDD, 4'b0101, 1'b0, 2, "aw_first");
        checks++;
        if (reg_o[32*2 +: 32] !== 32'h00BB00DD || reg_o[32*3 +: 32] !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL split_strobe: reg2=%h reg3=%h required 00bb00dd", reg_o[32*2 +: 32], reg_o[32*3 +: 32]);
        end
        checks++;
        if (b_hs_cnt - start !== 2) begin
            errors++;
            $display("FAIL split_b_count: got %0d required 2", b_hs_cnt - start);
        end
        do_read(BASE + 8, "rd_split");
    endtask

    task automatic test_b_stall();
        logic [1:0] held;
        bready = 1'b0;
        awaddr = BASE + 16; wdata = 32'h11112222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        b_q.push_back(exp_bresp(BASE + 16));
        model_write(BASE + 16, 32'h11112222, 4'hF);
        held = b_q[0];
        // Second write is presented while B is stalled; it must wait.
        awaddr = BASE + 20; wdata = 32'h33334444; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({bvalid, awready, wready} !== 3'b100 || bresp !== held) begin
                errors++;
                $display("FAIL stall_cycle%0d: bvalid,awready,wready=%b bresp=%b required 100/%b",
                         c, {bvalid, awready, wready}, bresp, held);
            end
            tick();
        end
        bready = 1'b1;
        tick();
        void'(b_q.pop_front());
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: bvalid=%b awready=%b required 0/1", bvalid, awready);
        end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        b_q.push_back(exp_bresp(BASE + 20));
        model_write(BASE + 20, 32'h33334444, 4'hF);
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL stall_second_b: bvalid=%b required 1", bvalid);
        end
        wait_b("stall_second");
        checks++;
        if (reg_o[32*4 +: 32] !== model[4] || reg_o[32*5 +: 32] !== model[5]) begin
            errors++;
            $display("FAIL stall_regs: reg4=%h reg5=%h required %h %h",
                     reg_o[32*4 +: 32], reg_o[32*5 +: 32], model[4], model[5]);
        end
    endtask

    task automatic test_miss();
        do_read(BASE + 64, "rd_miss_above");
        do_read(BASE - 4, "rd_miss_below");
        do_read(BASE + 60, "rd_last_reg");
        do_write(BASE + 64, 32'hFFFFFFFF, 4'hF, "wr_miss");
        do_write(BASE, 32'hCAFEF00D, 4'hF, "wr_id");
        do_read(BASE, "rd_id_after_write");
        do_write(BASE + 7, 32'h12345678, 4'hF, "wr_unaligned");
        do_read(BASE + 5, "rd_unaligned");
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++;
            if (reg_o[32*i +: 32] !== model[i] || pulse_cnt[i] !== exp_pulse[i]) begin
                errors++;
                $display("FAIL miss_reg%0d: got %h pulses %0d required %h pulses %0d",
                         i, reg_o[32*i +: 32], pulse_cnt[i], model[i], exp_pulse[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        rd_exp_t e;
        logic [1:0] eb;
        araddr = BASE + 4; awaddr = BASE + 4; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        r_q.push_back(exp_read(BASE + 4));
        b_q.push_back(exp_bresp(BASE + 4));
        model_write(BASE + 4, 32'h5A5A5A5A, 4'hF);
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        e  = r_q.pop_front();
        eb = b_q.pop_front();
        checks++;
        if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
            errors++;
            $display("FAIL same_edge_read: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, e.data);
        end
        checks++;
        if (bvalid !== 1'b1 || bresp !== eb) begin
            errors++;
            $display("FAIL same_edge_write: bvalid=%b bresp=%b required 1/%b", bvalid, bresp, eb);
        end
        tick();
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || reg_o[32 +: 32] !== model[1]) begin
            errors++;
            $display("FAIL same_edge_done: rvalid=%b bvalid=%b reg1=%h required 0/0/%h",
                     rvalid, bvalid, reg_o[32 +: 32], model[1]);
        end
    endtask

    task automatic test_reset_mid();
        awaddr = BASE + 24; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rready = 1'b0; araddr = BASE + 4; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        checks++;
        if ({awready, wready, rvalid} !== 3'b011) begin
            errors++;
            $display("FAIL mid_setup: awready,wready,rvalid=%b required 011", {awready, wready, rvalid});
        end
        rst = 1'b1;
        tick();
        for (int i = 1; i < NUM_REGS; i++) model[i] = 32'h0;
        b_q.delete();
        r_q.delete();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || rdata !== 32'h0 ||
            bresp !== 2'b0 || rresp !== 2'b0 || wr_pulse_o !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rdy=%b%b%b valid=%b%b rdata=%h required all 0",
                     awready, wready, arready, bvalid, rvalid, rdata);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++;
            if (reg_o[32*i +: 32] !== model[i]) begin
                errors++;
                $display("FAIL mid_reset_reg%0d: got %h required %h", i, reg_o[32*i +: 32], model[i]);
            end
        end
        tick();
        rst = 1'b0; rready = 1'b1;
        repeat (2) tick();
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_response: bvalid=%b rvalid=%b required 0/0", bvalid, rvalid);
        end
        do_write(BASE + 24, 32'hFEEDC0DE, 4'hF, "post_reset_wr");
        do_read(BASE + 24, "post_reset_rd");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_split();
        test_b_stall();
        test_miss();
        test_simultaneous();
        test_reset_mid();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
